alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Sequential front-end that issues operations to the combinational 16-bit ALU and collects results. It accepts commands on a valid/ready channel and reads operands from a small internal register file or an immediate. It drives the ALU operand/select/mode inputs from registers, captures the ALU result into the register file, and returns it on a valid/ready response channel. It sits between the instruction/control path and the ALU instance.

Parameters:
WIDTH, 16, datapath width; matches ALU operand/result width
NREGS, 4, number of internal general registers
REG_AW, 2, register index width (log2 NREGS)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_mode  in  1  ALU mode (1 = logic, 0 = arithmetic)
cmd_select  in  4  ALU function select
cmd_src_a  in  REG_AW  register index for operand A
cmd_src_b  in  REG_AW  register index for operand B
cmd_b_imm  in  1  1 = operand B taken from cmd_imm
cmd_imm  in  WIDTH  immediate operand B
cmd_dst  in  REG_AW  destination register index
alu_a  out  WIDTH  to ALU in_a
alu_b  out  WIDTH  to ALU in_b
alu_select  out  4  to ALU select
alu_mode  out  1  to ALU mode
alu_result  in  WIDTH  from ALU alu_out (combinational)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  WIDTH  result value
rsp_dst  out  REG_AW  destination index of result
op_count  out  16  completed-operation counter

Behaviour:
- Reset: the clock and reset are one clock `clk` and an asynchronous, active-low reset `rst_n`. Assertion takes effect immediately, regardless of clk. It sets the FSM to IDLE and clears every register to 0. Cleared: all NREGS registers, alu_a, alu_b, alu_select, alu_mode, rsp_valid, rsp_data, rsp_dst, op_count. After reset, cmd_ready is 1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready (accept edge), register the ALU inputs:
    - alu_a <= reg[cmd_src_a]
    - alu_b <= cmd_b_imm ? cmd_imm : reg[cmd_src_b]
    - alu_select <= cmd_select
    - alu_mode <= cmd_mode
  - Latch cmd_dst internally, then go to EXEC.
- EXEC (exactly one cycle):
  - cmd_ready = 0.
  - ALU outputs are stable and alu_result is sampled at the closing edge.
  - At that edge: reg[dst] <= alu_result, rsp_data <= alu_result, rsp_dst <= dst, rsp_valid <= 1; go to RESP.
- RESP:
  - cmd_ready = 0; rsp_valid, rsp_data and rsp_dst are held stable.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, op_count <= op_count + 1 (wraps 0xFFFF -> 0x0000), go to IDLE.
- Latency:
  - Accept at edge N, result written and rsp_valid high after edge N+1.
  - Earliest next accept is edge N+3; peak throughput is 1 op per 3 cycles.
- ALU outputs (alu_a/b/select/mode) hold their last values in IDLE and RESP; they change only on an accept edge.
- Register hazards: none by construction. The write-back at the EXEC edge precedes any later accept, so a dependent command reads the updated value.
- src_a = src_b = dst is allowed: operands are read before the write.
- Arithmetic and width are defined entirely by the ALU; the sequencer neither extends, truncates nor flags carry. Results are WIDTH bits.
- cmd fields are ignored when cmd_valid = 0 or cmd_ready = 0.
- rsp_ready asserted outside RESP has no effect.
- Reset mid-operation (EXEC or RESP): the command is dropped, no response is produced, registers are cleared, and op_count is not incremented.

Test Plan:
- Reset: hold rst_n = 0 mid-cycle -> all outputs 0 immediately; after release, cmd_ready = 1, rsp_valid = 0, op_count = 0.
- Load immediate: mode = 1, select = 1010, b_imm = 1, imm = 0x1234, dst = 1 -> alu_b = 0x1234 during EXEC; rsp_data = 0x1234, rsp_dst = 1 one cycle later; reg1 = 0x1234.
- Add: load r1 = 0x1234 and r2 = 0x0FFF, then mode = 0, select = 1001, src_a = 1, src_b = 2, dst = 3 -> rsp_data = 0x2233.
- Wrap and dependency: load r0 = 0xFFFF, then add imm 0x0002 with dst = 0, then immediately add imm 0x0001 -> responses 0x0001 then 0x0002. The second command reads the updated r0.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP with cmd_valid = 1 -> rsp_valid/rsp_data stable, cmd_ready = 0, op_count unchanged. It increments by 1 on the handshake cycle.
- Reset during EXEC with dst = 2 -> no rsp_valid pulse, reg2 = 0, op_count = 0. The next command completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one command at a time to an external combinational ALU
// and returns the result on a valid/ready response channel.
//
// Flow:   IDLE --accept--> EXEC (one cycle) --> RESP --rsp handshake--> IDLE
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. The producer holds its payload stable
// while valid is 1 and ready is 0. The payload is ignored when valid is 0.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   cmd_valid/cmd_ready command channel handshake
//   cmd_mode/select     ALU mode and function for the command
//   cmd_src_a/src_b     register indices of operands A and B
//   cmd_b_imm, cmd_imm  take operand B from cmd_imm instead of the register file
//   cmd_dst             destination register index
//   alu_a/b/select/mode registered drive to the ALU
//   alu_result          combinational result from the ALU
//   rsp_valid/rsp_ready response channel handshake
//   rsp_data, rsp_dst   result value and its destination index
//   op_count            number of completed responses (wraps)
module alu_sequencer #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [3:0]        cmd_select,
    input  logic [REG_AW-1:0] cmd_src_a,
    input  logic [REG_AW-1:0] cmd_src_b,
    input  logic              cmd_b_imm,
    input  logic [WIDTH-1:0]  cmd_imm,
    input  logic [REG_AW-1:0] cmd_dst,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [3:0]        alu_select,
    output logic              alu_mode,
    input  logic [WIDTH-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [REG_AW-1:0] rsp_dst,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  regs [NREGS];
    logic [REG_AW-1:0] dst_q;
    logic              accept;
    logic              rsp_fire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                if (cmd_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_fire = rsp_valid & rsp_ready;
                if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: ALU drive, register file write-back, response payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            alu_mode   <= 1'b0;
            dst_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_dst    <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                // Operands are read here, before any write-back of this
                // command, so src == dst reads the old value.
                alu_a      <= regs[cmd_src_a];
                alu_b      <= cmd_b_imm ? cmd_imm : regs[cmd_src_b];
                alu_select <= cmd_select;
                alu_mode   <= cmd_mode;
                dst_q      <= cmd_dst;
            end
            if (state == EXEC) begin
                regs[dst_q] <= alu_result;
                rsp_data    <= alu_result;
                rsp_dst     <= dst_q;
                rsp_valid   <= 1'b1;
            end
            if (rsp_fire) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. A small behavioural stand-in for the ALU
// supplies alu_result; only the functions used below are modelled.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [3:0]  cmd_select;
    logic [1:0]  cmd_src_a;
    logic [1:0]  cmd_src_b;
    logic        cmd_b_imm;
    logic [15:0] cmd_imm;
    logic [1:0]  cmd_dst;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_select;
    logic        alu_mode;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_dst;
    logic [15:0] op_count;

    int errors;
    int checks;

    alu_sequencer #(.WIDTH(16), .NREGS(4), .REG_AW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_select (cmd_select),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_b_imm  (cmd_b_imm),
        .cmd_imm    (cmd_imm),
        .cmd_dst    (cmd_dst),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_dst    (rsp_dst),
        .op_count   (op_count)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: logic 1010 -> B, logic 1111 -> A, arith 1001 -> A plus B
    always_comb begin
        alu_result = alu_a ^ alu_b;
        if (alu_mode && alu_select == 4'b1010) alu_result = alu_b;
        else if (alu_mode && alu_select == 4'b1111) alu_result = alu_a;
        else if (!alu_mode && alu_select == 4'b1001) alu_result = alu_a + alu_b;
    end

    // Driver: called at a negedge with the DUT in IDLE; returns at the next
    // negedge, which falls inside EXEC.
    task automatic drive_cmd(input logic mode, input logic [3:0] sel,
                             input logic [1:0] src_a, input logic [1:0] src_b,
                             input logic b_imm, input logic [15:0] imm,
                             input logic [1:0] dst);
        cmd_mode   = mode;
        cmd_select = sel;
        cmd_src_a  = src_a;
        cmd_src_b  = src_b;
        cmd_b_imm  = b_imm;
        cmd_imm    = imm;
        cmd_dst    = dst;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Driver: waits (bounded) for rsp_valid, captures payload, completes the
    // handshake and returns at the negedge after it (DUT back in IDLE).
    task automatic get_rsp(output logic [15:0] data, output logic [1:0] dst,
                           output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        data      = rsp_data;
        dst       = rsp_dst;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (alu_a !== 16'h0) begin errors++; $display("FAIL reset_alu_a: got %h expected 0000", alu_a); end
        checks++; if (alu_b !== 16'h0) begin errors++; $display("FAIL reset_alu_b: got %h expected 0000", alu_b); end
        checks++; if (alu_select !== 4'h0) begin errors++; $display("FAIL reset_alu_select: got %h expected 0", alu_select); end
        checks++; if (alu_mode !== 1'b0) begin errors++; $display("FAIL reset_alu_mode: got %b expected 0", alu_mode); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
        checks++; if (rsp_dst !== 2'd0) begin errors++; $display("FAIL reset_rsp_dst: got %0d expected 0", rsp_dst); end
        checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count: got %h expected 0000", op_count); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rsp_valid: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_load_imm;
        logic [15:0] d;
        logic [1:0]  t;
        bit          ok;
        drive_cmd(1'b1, 4'b1010, 2'd0, 2'd0, 1'b1, 16'h1234, 2'd1);
        // Inside EXEC
        checks++; if (alu_b !== 16'h1234) begin errors++; $display("FAIL load_alu_b: got %h expected 1234", alu_b); end
        checks++; if (alu_select !== 4'b1010) begin errors++; $display("FAIL load_alu_select: got %b expected 1010", alu_select); end
        checks++; if (alu_mode !== 1'b1) begin errors++; $display("FAIL load_alu_mode: got %b expected 1", alu_mode); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL load_exec_cmd_ready: got %b expected 0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL load_exec_rsp_valid: got %b expected 0", rsp_valid); end
        @(negedge clk);
        // One cycle later: RESP
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL load_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_data !== 16'h1234) begin errors++; $display("FAIL load_rsp_data: got %h expected 1234", rsp_data); end
        checks++; if (rsp_dst !== 2'd1) begin errors++; $display("FAIL load_rsp_dst: got %0d expected 1", rsp_dst); end
        get_rsp(d, t, ok);
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL load_op_count: got %0d expected 1", op_count); end
    endtask

    task automatic test_add;
        logic [15:0] d;
        logic [1:0]  t;
        bit          ok;
        drive_cmd(1'b1, 4'b1010, 2'd0, 2'd0, 1'b1, 16'h0FFF, 2'd2);
        get_rsp(d, t, ok);
        checks++; if (!ok || d !== 16'h0FFF) begin errors++; $display("FAIL add_load_r2: got %h ok=%0d expected 0fff", d, ok); end
        // imm is junk but b_imm = 0, so B must come from r2
        drive_cmd(1'b0, 4'b1001, 2'd1, 2'd2, 1'b0, 16'hAAAA, 2'd3);
        checks++; if (alu_a !== 16'h1234) begin errors++; $display("FAIL add_alu_a: got %h expected 1234", alu_a); end
        checks++; if (alu_b !== 16'h0FFF) begin errors++; $display("FAIL add_alu_b: got %h expected 0fff", alu_b); end
        get_rsp(d, t, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_timeout: got no rsp_valid expected rsp_valid"); end
        checks++; if (d !== 16'h2233) begin errors++; $display("FAIL add_rsp_data: got %h expected 2233", d); end
        checks++; if (t !== 2'd3) begin errors++; $display("FAIL add_rsp_dst: got %0d expected 3", t); end
        checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL add_op_count: got %0d expected 3", op_count); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        logic [1:0]  t;
        bit          ok;
        drive_cmd(1'b1, 4'b1010, 2'd0, 2'd0, 1'b1, 16'hFFFF, 2'd0);
        get_rsp(d, t, ok);
        checks++; if (!ok || d !== 16'hFFFF) begin errors++; $display("FAIL b2b_load_r0: got %h ok=%0d expected ffff", d, ok); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_n3: got %b expected 1", cmd_ready); end
        drive_cmd(1'b0, 4'b1001, 2'd0, 2'd3, 1'b1, 16'h0002, 2'd0);
        get_rsp(d, t, ok);
        checks++; if (!ok || d !== 16'h0001) begin errors++; $display("FAIL b2b_wrap: got %h ok=%0d expected 0001", d, ok); end
        drive_cmd(1'b0, 4'b1001, 2'd0, 2'd3, 1'b1, 16'h0001, 2'd0);
        checks++; if (alu_a !== 16'h0001) begin errors++; $display("FAIL b2b_dep_alu_a: got %h expected 0001", alu_a); end
        get_rsp(d, t, ok);
        checks++; if (!ok || d !== 16'h0002) begin errors++; $display("FAIL b2b_dep: got %h ok=%0d expected 0002", d, ok); end
        checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL b2b_op_count: got %0d expected 6", op_count); end
    endtask

    task automatic test_backpressure;
        drive_cmd(1'b1, 4'b1111, 2'd3, 2'd0, 1'b0, 16'h0000, 2'd1);
        @(negedge clk);
        // A competing command waits while the response is stalled
        cmd_mode   = 1'b0;
        cmd_select = 4'b1001;
        cmd_src_a  = 2'd0;
        cmd_src_b  = 2'd0;
        cmd_b_imm  = 1'b1;
        cmd_imm    = 16'h5A5A;
        cmd_dst    = 2'd2;
        cmd_valid  = 1'b1;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 1", i, rsp_valid); end
            checks++; if (rsp_data !== 16'h2233) begin errors++; $display("FAIL bp_rsp_data[%0d]: got %h expected 2233", i, rsp_data); end
            checks++; if (rsp_dst !== 2'd1) begin errors++; $display("FAIL bp_rsp_dst[%0d]: got %0d expected 1", i, rsp_dst); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready[%0d]: got %b expected 0", i, cmd_ready); end
            checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL bp_op_count[%0d]: got %0d expected 6", i, op_count); end
            checks++; if (alu_a !== 16'h2233) begin errors++; $display("FAIL bp_alu_a[%0d]: got %h expected 2233", i, alu_a); end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (op_count !== 16'd7) begin errors++; $display("FAIL bp_op_count_fire: got %0d expected 7", op_count); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_valid_fire: got %b expected 0", rsp_valid); end
        // rsp_ready held while IDLE changes nothing
        @(negedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (op_count !== 16'd7) begin errors++; $display("FAIL idle_rsp_ready_count: got %0d expected 7", op_count); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_rsp_ready_state: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_reset_exec;
        logic [15:0] d;
        logic [1:0]  t;
        bit          ok;
        bit          seen;
        drive_cmd(1'b1, 4'b1010, 2'd0, 2'd0, 1'b1, 16'h5555, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (alu_b !== 16'h0) begin errors++; $display("FAIL rexec_alu_b: got %h expected 0000", alu_b); end
        checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL rexec_op_count: got %0d expected 0", op_count); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rexec_no_rsp: got rsp_valid=1 expected 0"); end
        // Read r2 back through the ALU pass-through of A
        drive_cmd(1'b1, 4'b1111, 2'd2, 2'd0, 1'b0, 16'h0000, 2'd3);
        get_rsp(d, t, ok);
        checks++; if (!ok || d !== 16'h0000) begin errors++; $display("FAIL rexec_r2: got %h ok=%0d expected 0000", d, ok); end
        drive_cmd(1'b1, 4'b1111, 2'd1, 2'd0, 1'b0, 16'h0000, 2'd0);
        get_rsp(d, t, ok);
        checks++; if (!ok || d !== 16'h0000) begin errors++; $display("FAIL rexec_r1: got %h ok=%0d expected 0000", d, ok); end
        checks++; if (op_count !== 16'd2) begin errors++; $display("FAIL rexec_op_count_after: got %0d expected 2", op_count); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = 1'b0;
        cmd_select = 4'h0;
        cmd_src_a  = 2'd0;
        cmd_src_b  = 2'd0;
        cmd_b_imm  = 1'b0;
        cmd_imm    = 16'h0;
        cmd_dst    = 2'd0;
        rsp_ready  = 1'b0;
        test_reset();
        test_load_imm();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
